// File: rtl/gcd_binary_if.sv
// Handshake bundle for gcd_binary: operands, start/busy/done, result and zero flag.
// Optional build macro GCD_CYCLES_EN adds the busy-cycle counter output.
interface gcd_binary_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_in;
`ifdef GCD_CYCLES_EN
  logic [$clog2(4*WIDTH+5)-1:0] cycles;

  modport master (output start, a, b, input busy, done, result, zero_in, cycles);
  modport slave  (input start, a, b, output busy, done, result, zero_in, cycles);
`else
  modport master (output start, a, b, input busy, done, result, zero_in);
  modport slave  (input start, a, b, output busy, done, result, zero_in);
`endif
endinterface

// File: rtl/gcd_binary.sv
// Binary (Stein) GCD engine: one shift or one subtract per cycle, start/busy/done handshake.
// Optional build macro GCD_CYCLES_EN adds a counter of busy cycles on bus.cycles.
module gcd_binary #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  gcd_binary_if.slave bus
);

  typedef enum logic [2:0] {IDLE, STRIP, ALIGN, REDUCE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ar_reg, ar_next;
  logic [WIDTH-1:0] br_reg, br_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             zero_reg, zero_next;
  logic             accept;

`ifdef GCD_CYCLES_EN
  localparam int CW = $clog2(4*WIDTH + 5);
  logic [CW-1:0] cycles_reg, cycles_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ar_reg     <= '0;
      br_reg     <= '0;
      k_reg      <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      zero_reg   <= 1'b0;
`ifdef GCD_CYCLES_EN
      cycles_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      ar_reg     <= ar_next;
      br_reg     <= br_next;
      k_reg      <= k_next;
      result_reg <= result_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      zero_reg   <= zero_next;
`ifdef GCD_CYCLES_EN
      cycles_reg <= cycles_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    ar_next     = ar_reg;
    br_next     = br_reg;
    k_next      = k_reg;
    result_next = result_reg;
    busy_next   = busy_reg;
    done_next   = done_reg;
    zero_next   = zero_reg;
    accept      = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          ar_next    = bus.a;
          br_next    = bus.b;
          k_next     = '0;
          done_next  = 1'b0;
          zero_next  = 1'b0;
          busy_next  = 1'b1;
          state_next = STRIP;
        end
      end
      STRIP: begin
        // Zero operands are resolved here; once both are nonzero shifting keeps them so.
        if (ar_reg == '0 || br_reg == '0) begin
          result_next = ar_reg | br_reg;
          zero_next   = (ar_reg == '0) && (br_reg == '0);
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = DONE;
        end else if (!ar_reg[0] && !br_reg[0]) begin
          ar_next = ar_reg >> 1;
          br_next = br_reg >> 1;
          k_next  = k_reg + KW'(1);
        end else begin
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (!ar_reg[0]) ar_next = ar_reg >> 1;
        else            state_next = REDUCE;
      end
      REDUCE: begin
        // ar stays odd, so the smaller odd value is always kept in ar.
        if (br_reg == '0) begin
          result_next = ar_reg << k_reg;
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = DONE;
        end else if (!br_reg[0]) begin
          br_next = br_reg >> 1;
        end else if (ar_reg > br_reg) begin
          ar_next = br_reg;
          br_next = ar_reg - br_reg;
        end else begin
          br_next = br_reg - ar_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef GCD_CYCLES_EN
  always_comb begin
    cycles_next = cycles_reg;
    if (accept)        cycles_next = '0;
    else if (busy_reg) cycles_next = cycles_reg + CW'(1);
  end

  assign bus.cycles = cycles_reg;
`endif

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.zero_in = zero_reg;

endmodule
